// File: rtl/id_branch_sequencer_pkg.sv
// Shared definitions for the ID-stage branch delay-slot sequencer: state
// encoding, MIPS opcode/funct field values and the slot-count helper.
package id_branch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_ANNUL = 2'd2
  } seq_state_e;

  // Primary opcode field (instr[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_BEQL    = 6'h14;
  localparam logic [5:0] OP_BNEL    = 6'h15;
  localparam logic [5:0] OP_BLEZL   = 6'h16;
  localparam logic [5:0] OP_BGTZL   = 6'h17;

  // Function field (instr[5:0]).
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ERET    = 6'h18;

  // Number of delay slots the decoded control transfer owns.
  function automatic logic [1:0] eff_slots(input logic       is_eret,
                                           input logic       eret_slot,
                                           input logic [1:0] delay_slots);
    return (is_eret && !eret_slot) ? 2'd0 : delay_slots;
  endfunction

endpackage

// File: rtl/id_branch_sequencer_slot_counter.sv
// Loadable down-counter tracking delay slots still to come after the
// current one; clear has priority over load, load over decrement.
module id_branch_sequencer_slot_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic [1:0] count,
  output logic       zero
);

  logic [1:0] count_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 2'd0)) begin
      count_q <= count_q - 2'd1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 2'd0);

endmodule

// File: rtl/id_branch_sequencer.sv
// ID-stage delay-slot sequencer: tracks the slots following a control
// transfer, marks/annuls slot instructions and times the fetch redirect.
module id_branch_sequencer #(
  parameter int DELAY_SLOTS = 1,
  parameter int LIKELY_EN   = 1,
  parameter int ERET_SLOT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        is_branch,
  input  logic        is_likely,
  input  logic        is_eret,
  input  logic        taken,
  input  logic [31:0] id_pc,
  output logic        redirect,
  output logic        in_slot,
  output logic        annul,
  output logic [31:0] epc_base,
  output logic [1:0]  slots_left,
  output logic        slot_err
);

  import id_branch_sequencer_pkg::*;

  seq_state_e  state_q, state_d;
  logic [31:0] branch_pc_q;
  logic        tkn_q;

  logic        advance;
  logic        likely_eff;
  logic [1:0]  n_eff;
  logic        capture;
  logic        load_cnt;
  logic        dec_cnt;
  logic        redirect_c;
  logic [1:0]  cnt_q;
  logic        cnt_zero;

  assign advance    = id_valid & ~stall & ~flush;
  assign likely_eff = (LIKELY_EN != 0) & is_likely;
  assign n_eff      = eff_slots(is_eret, ERET_SLOT != 0, 2'(DELAY_SLOTS));

  id_branch_sequencer_slot_counter u_slot_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .load     (load_cnt),
    .load_val (n_eff - 2'd1),
    .dec      (dec_cnt),
    .count    (cnt_q),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_pc_q <= 32'd0;
      tkn_q       <= 1'b0;
    end else if (flush) begin
      tkn_q       <= 1'b0;
    end else if (capture) begin
      branch_pc_q <= id_pc;
      tkn_q       <= taken;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    redirect_c = 1'b0;
    in_slot    = 1'b0;
    annul      = 1'b0;
    epc_base   = id_pc;
    slots_left = 2'd0;
    slot_err   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (advance && is_branch) begin
          if (n_eff == 2'd0) begin
            redirect_c = taken;
          end else begin
            capture  = 1'b1;
            load_cnt = 1'b1;
            state_d  = (likely_eff && !taken) ? ST_ANNUL : ST_SLOT;
          end
        end
      end
      ST_SLOT, ST_ANNUL: begin
        in_slot    = 1'b1;
        annul      = (state_q == ST_ANNUL);
        epc_base   = branch_pc_q;
        slots_left = cnt_q;
        // A branch in a slot is reported and otherwise ignored.
        slot_err   = advance & is_branch;
        if (advance) begin
          if (cnt_zero) begin
            state_d    = ST_IDLE;
            redirect_c = tkn_q;
          end else begin
            dec_cnt = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // A zero-slot transfer decodes combinationally from the inputs, so it is
  // masked explicitly while reset is held.
  assign redirect = redirect_c & reset_n;

endmodule

// File: tb/tb_id_branch_sequencer.sv
// Bench for id_branch_sequencer: directed vector table, hand sequences and
// randomized stimulus against a slot-counting reference model.
module tb_id_branch_sequencer;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        st;
    logic        fl;
    logic        br;
    logic        lk;
    logic        er;
    logic        tk;
    logic [31:0] pc;
  } in_t;

  typedef struct packed {
    logic        redirect;
    logic        in_slot;
    logic        annul;
    logic [31:0] epc;
    logic [1:0]  slots_left;
    logic        slot_err;
  } outs_t;

  typedef struct {
    in_t   i;
    outs_t e;
  } vec_t;

  // Reference model: a sequence is "the next `remaining` instructions
  // including the current one belong to the branch at owner_pc".
  typedef struct {
    int          ds;
    bit          eret_slot;
    bit          likely_en;
    bit          in_seq;
    int          remaining;
    bit          annulling;
    bit          will_redirect;
    logic [31:0] owner_pc;
  } mdl_t;

  logic        clk, reset_n, id_valid, stall, flush;
  logic        is_branch, is_likely, is_eret, taken;
  logic [31:0] id_pc;

  logic        a_redirect, a_in_slot, a_annul, a_slot_err;
  logic [31:0] a_epc;
  logic [1:0]  a_slots_left;
  logic        b_redirect, b_in_slot, b_annul, b_slot_err;
  logic [31:0] b_epc;
  logic [1:0]  b_slots_left;

  outs_t act_a, act_b;
  assign act_a = {a_redirect, a_in_slot, a_annul, a_epc, a_slots_left, a_slot_err};
  assign act_b = {b_redirect, b_in_slot, b_annul, b_epc, b_slots_left, b_slot_err};

  int n_cmp = 0;
  int n_mis = 0;

  id_branch_sequencer #(.DELAY_SLOTS(1), .LIKELY_EN(1), .ERET_SLOT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .stall(stall),
    .flush(flush), .is_branch(is_branch), .is_likely(is_likely),
    .is_eret(is_eret), .taken(taken), .id_pc(id_pc),
    .redirect(a_redirect), .in_slot(a_in_slot), .annul(a_annul),
    .epc_base(a_epc), .slots_left(a_slots_left), .slot_err(a_slot_err)
  );

  id_branch_sequencer #(.DELAY_SLOTS(2), .LIKELY_EN(1), .ERET_SLOT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .stall(stall),
    .flush(flush), .is_branch(is_branch), .is_likely(is_likely),
    .is_eret(is_eret), .taken(taken), .id_pc(id_pc),
    .redirect(b_redirect), .in_slot(b_in_slot), .annul(b_annul),
    .epc_base(b_epc), .slots_left(b_slots_left), .slot_err(b_slot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(logic rst, logic v, logic st, logic fl, logic br,
                                logic lk, logic er, logic tk, logic [31:0] pc);
    return '{rst: rst, v: v, st: st, fl: fl, br: br, lk: lk, er: er, tk: tk, pc: pc};
  endfunction

  function automatic outs_t mk_out(logic rd, logic is, logic an, logic [31:0] epc,
                                   logic [1:0] sl, logic se);
    return '{redirect: rd, in_slot: is, annul: an, epc: epc, slots_left: sl, slot_err: se};
  endfunction

  function automatic mdl_t mdl_reset(mdl_t m);
    m.in_seq        = 1'b0;
    m.remaining     = 0;
    m.annulling     = 1'b0;
    m.will_redirect = 1'b0;
    m.owner_pc      = 32'd0;
    return m;
  endfunction

  function automatic int mdl_slots(mdl_t m, in_t i);
    return (i.er && !m.eret_slot) ? 0 : m.ds;
  endfunction

  function automatic outs_t mdl_out(mdl_t m, in_t i);
    outs_t o;
    bit adv;
    adv = i.v && !i.st && !i.fl;
    o = mk_out(1'b0, 1'b0, 1'b0, i.pc, 2'd0, 1'b0);
    if (!i.rst) return o;
    if (!m.in_seq) begin
      o.redirect = adv && i.br && (mdl_slots(m, i) == 0) && i.tk;
    end else begin
      o.in_slot    = 1'b1;
      o.annul      = m.annulling;
      o.epc        = m.owner_pc;
      o.slots_left = 2'(m.remaining - 1);
      o.slot_err   = adv && i.br;
      o.redirect   = adv && (m.remaining == 1) && m.will_redirect;
    end
    return o;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, in_t i);
    if (!i.rst || i.fl) return mdl_reset(m);
    if (!(i.v && !i.st)) return m;
    if (m.in_seq) begin
      m.remaining = m.remaining - 1;
      if (m.remaining == 0) m = mdl_reset(m);
    end else if (i.br && mdl_slots(m, i) > 0) begin
      m.in_seq        = 1'b1;
      m.remaining     = mdl_slots(m, i);
      m.annulling     = m.likely_en && i.lk && !i.tk;
      m.will_redirect = i.tk;
      m.owner_pc      = i.pc;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t act, input outs_t exp);
    check({tag, ".redirect"},   32'(act.redirect),   32'(exp.redirect));
    check({tag, ".in_slot"},    32'(act.in_slot),    32'(exp.in_slot));
    check({tag, ".annul"},      32'(act.annul),      32'(exp.annul));
    check({tag, ".epc_base"},   act.epc,             exp.epc);
    check({tag, ".slots_left"}, 32'(act.slots_left), 32'(exp.slots_left));
    check({tag, ".slot_err"},   32'(act.slot_err),   32'(exp.slot_err));
  endtask

  task automatic drive(input in_t i);
    reset_n   = i.rst;
    id_valid  = i.v;
    stall     = i.st;
    flush     = i.fl;
    is_branch = i.br;
    is_likely = i.lk;
    is_eret   = i.er;
    taken     = i.tk;
    id_pc     = i.pc;
  endtask

  // One cycle: inputs applied just after a rising edge, outputs checked on
  // the falling edge, then the next rising edge commits the state.
  task automatic step(input string tag, input bit use_b, input in_t i, input outs_t e);
    drive(i);
    @(negedge clk);
    check_outs(tag, use_b ? act_b : act_a, e);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[25];
  mdl_t ma, mb;

  initial begin
    drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

    // DELAY_SLOTS=1, LIKELY_EN=1, ERET_SLOT=0
    tbl[0]  = '{mk_in(0,0,0,0,0,0,0,0,32'h0000_0100), mk_out(0,0,0,32'h0000_0100,0,0)};
    tbl[1]  = '{mk_in(1,1,0,0,1,0,0,1,32'h0000_3000), mk_out(0,0,0,32'h0000_3000,0,0)};
    tbl[2]  = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3004), mk_out(1,1,0,32'h0000_3000,0,0)};
    tbl[3]  = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_5000), mk_out(0,0,0,32'h0000_5000,0,0)};
    tbl[4]  = '{mk_in(1,1,0,0,1,1,0,0,32'h0000_3000), mk_out(0,0,0,32'h0000_3000,0,0)};
    tbl[5]  = '{mk_in(1,0,0,0,0,0,0,0,32'h0000_3004), mk_out(0,1,1,32'h0000_3000,0,0)};
    tbl[6]  = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3004), mk_out(0,1,1,32'h0000_3000,0,0)};
    tbl[7]  = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3008), mk_out(0,0,0,32'h0000_3008,0,0)};
    tbl[8]  = '{mk_in(1,1,0,0,1,0,1,1,32'h0000_4180), mk_out(1,0,0,32'h0000_4180,0,0)};
    tbl[9]  = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_0200), mk_out(0,0,0,32'h0000_0200,0,0)};
    tbl[10] = '{mk_in(1,1,0,0,1,0,0,1,32'h0000_3100), mk_out(0,0,0,32'h0000_3100,0,0)};
    tbl[11] = '{mk_in(1,1,0,0,1,0,0,1,32'h0000_3104), mk_out(1,1,0,32'h0000_3100,0,1)};
    tbl[12] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_6000), mk_out(0,0,0,32'h0000_6000,0,0)};
    tbl[13] = '{mk_in(1,1,0,0,1,0,0,0,32'h0000_3200), mk_out(0,0,0,32'h0000_3200,0,0)};
    tbl[14] = '{mk_in(1,1,1,0,0,0,0,0,32'h0000_3204), mk_out(0,1,0,32'h0000_3200,0,0)};
    tbl[15] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3204), mk_out(0,1,0,32'h0000_3200,0,0)};
    tbl[16] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3208), mk_out(0,0,0,32'h0000_3208,0,0)};
    tbl[17] = '{mk_in(1,1,0,0,1,1,0,1,32'h0000_3300), mk_out(0,0,0,32'h0000_3300,0,0)};
    tbl[18] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3304), mk_out(1,1,0,32'h0000_3300,0,0)};
    tbl[19] = '{mk_in(1,1,0,0,1,0,0,1,32'h0000_3400), mk_out(0,0,0,32'h0000_3400,0,0)};
    tbl[20] = '{mk_in(1,1,0,1,0,0,0,0,32'h0000_3404), mk_out(0,1,0,32'h0000_3400,0,0)};
    tbl[21] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3408), mk_out(0,0,0,32'h0000_3408,0,0)};
    tbl[22] = '{mk_in(1,1,0,0,1,1,0,1,32'h0000_3500), mk_out(0,0,0,32'h0000_3500,0,0)};
    tbl[23] = '{mk_in(0,1,0,0,0,0,0,0,32'h0000_3504), mk_out(0,0,0,32'h0000_3504,0,0)};
    tbl[24] = '{mk_in(1,1,0,0,0,0,0,0,32'h0000_3504), mk_out(0,0,0,32'h0000_3504,0,0)};

    @(posedge clk);
    #1;
    for (int k = 0; k < 25; k++) begin
      step($sformatf("tbl[%0d]", k), 1'b0, tbl[k].i, tbl[k].e);
    end

    // DELAY_SLOTS=2: jal with the first slot stalled for three cycles.
    step("b_rst",     1'b1, mk_in(0,0,0,0,0,0,0,0,32'h0), mk_out(0,0,0,32'h0,0,0));
    step("b_jal",     1'b1, mk_in(1,1,0,0,1,0,0,1,32'h3000), mk_out(0,0,0,32'h3000,0,0));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("b_stall%0d", k), 1'b1, mk_in(1,1,1,0,0,0,0,0,32'h3004),
           mk_out(0,1,0,32'h3000,1,0));
    end
    step("b_slot1",   1'b1, mk_in(1,1,0,0,0,0,0,0,32'h3004), mk_out(0,1,0,32'h3000,1,0));
    step("b_slot2",   1'b1, mk_in(1,1,0,0,0,0,0,0,32'h3008), mk_out(1,1,0,32'h3000,0,0));
    step("b_target",  1'b1, mk_in(1,1,0,0,0,0,0,0,32'h7000), mk_out(0,0,0,32'h7000,0,0));
    // Flush with one further slot outstanding.
    step("b_br",      1'b1, mk_in(1,1,0,0,1,0,0,1,32'h3100), mk_out(0,0,0,32'h3100,0,0));
    step("b_flush",   1'b1, mk_in(1,1,0,1,0,0,0,0,32'h3104), mk_out(0,1,0,32'h3100,1,0));
    step("b_postfl",  1'b1, mk_in(1,1,0,0,0,0,0,0,32'h3108), mk_out(0,0,0,32'h3108,0,0));
    // ERET_SLOT=1: eret owns two slots.
    step("b_eret",    1'b1, mk_in(1,1,0,0,1,0,1,1,32'h4180), mk_out(0,0,0,32'h4180,0,0));
    step("b_eslot1",  1'b1, mk_in(1,1,0,0,0,0,0,0,32'h4184), mk_out(0,1,0,32'h4180,1,0));
    step("b_eslot2",  1'b1, mk_in(1,1,0,0,0,0,0,0,32'h4188), mk_out(1,1,0,32'h4180,0,0));

    // Randomized run of both configurations against the model.
    ma = '{ds: 1, eret_slot: 1'b0, likely_en: 1'b1, default: 0};
    mb = '{ds: 2, eret_slot: 1'b1, likely_en: 1'b1, default: 0};
    ma = mdl_reset(ma);
    mb = mdl_reset(mb);
    drive(mk_in(0,0,0,0,0,0,0,0,32'h0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3000; k++) begin
      in_t   ri;
      outs_t ea, eb;
      logic [31:0] r;
      r = $urandom();
      ri.rst = ($urandom_range(0, 99) != 0);
      ri.v   = ($urandom_range(0, 99) < 85);
      ri.st  = ($urandom_range(0, 99) < 15);
      ri.fl  = ($urandom_range(0, 99) < 5);
      ri.er  = ($urandom_range(0, 99) < 8);
      ri.br  = ri.er || ($urandom_range(0, 99) < 30);
      ri.lk  = !ri.er && ($urandom_range(0, 99) < 30);
      ri.tk  = ri.er || ($urandom_range(0, 1) == 1);
      ri.pc  = r & 32'hFFFF_FFFC;
      drive(ri);
      @(negedge clk);
      ea = mdl_out(ma, ri);
      eb = mdl_out(mb, ri);
      check_outs($sformatf("rnd_a[%0d]", k), act_a, ea);
      check_outs($sformatf("rnd_b[%0d]", k), act_b, eb);
      @(posedge clk);
      ma = mdl_step(ma, ri);
      mb = mdl_step(mb, ri);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/id_branch_sequencer.md
ID_BRANCH_SEQUENCER -- requirements
Module: id_branch_sequencer

Interface
REQ-001 Parameter DELAY_SLOTS, default 1, number of delay slots after a control transfer (legal 0..3).
REQ-002 Parameter LIKELY_EN, default 1; 1 enables branch-likely annulment, 0 treats is_likely as 0.
REQ-003 Parameter ERET_SLOT, default 0; 1 gives eret DELAY_SLOTS slots, 0 gives eret none.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 stall  input  1  ID held this cycle; no advance.
REQ-008 flush  input  1  exception/redirect from later stage; kills sequence.
REQ-009 is_branch  input  1  ID instruction is branch/jump (incl. eret).
REQ-010 is_likely  input  1  ID branch is branch-likely.
REQ-011 is_eret  input  1  ID instruction is eret.
REQ-012 taken  input  1  comparer result for ID branch (1 for unconditional).
REQ-013 id_pc  input  32  PC of ID instruction.
REQ-014 redirect  output  1  combinational: select branch target for next fetch.
REQ-015 in_slot  output  1  ID instruction is a delay-slot instruction (CP0 BD).
REQ-016 annul  output  1  ID instruction shall be converted to nop.
REQ-017 epc_base  output  32  PC for EPC: owning branch PC when in_slot, else id_pc.
REQ-018 slots_left  output  2  delay slots remaining after current one.
REQ-019 slot_err  output  1  one-cycle pulse: branch decoded inside a delay slot.

Function
REQ-020 Advance = id_valid & ~stall & ~flush; all state changes only on advance, except flush.
REQ-021 States IDLE, SLOT, ANNUL.
REQ-022 IDLE: advance with is_branch and effective slot count N>0 -> SLOT (taken or likely-taken) or ANNUL (likely not taken), count<=N-1, branch_pc<=id_pc, tkn<=taken.
REQ-023 Effective N = 0 for eret when ERET_SLOT=0, else DELAY_SLOTS.
REQ-024 N=0: redirect=taken in same cycle, state stays IDLE, next fetched instruction is the target.
REQ-025 N>0: redirect asserted on the advance of the last delay slot when tkn=1; never on the branch cycle.
REQ-026 SLOT/ANNUL: in_slot=1, epc_base=branch_pc; each advance with count=0 -> IDLE, else count-1.
REQ-027 ANNUL: annul=1 for every slot instruction; SLOT and IDLE: annul=0.
REQ-028 Non-likely not-taken branch enters SLOT with tkn=0; slots execute, redirect=0.
REQ-029 Branch decoded in SLOT/ANNUL: slot_err pulses, instruction treated as non-branch, sequence continues.
REQ-030 stall: all state held; outputs reflect held state; redirect deasserted.
REQ-031 flush: next edge state<=IDLE, count<=0, tkn<=0 regardless of stall/advance; flush wins over advance.
REQ-032 id_valid=0 (bubble): no count consumed; in_slot/annul still reflect state.
REQ-033 slots_left=count in SLOT/ANNUL, 0 in IDLE.
REQ-034 LIKELY_EN=0: ANNUL unreachable.

Reset
REQ-035 reset_n low: state IDLE, count 0, tkn 0, branch_pc 0 immediately, independent of clk.
REQ-036 During reset: redirect=0, in_slot=0, annul=0, slot_err=0, slots_left=0, epc_base=id_pc.
REQ-037 Reset deassertion mid-sequence resumes from IDLE; prior branch discarded.

Structure
REQ-038 State encoding and the shared MIPS opcode/funct field macros belong in the shared utility package.
REQ-039 One sub-module, slot_counter (loadable down-counter with zero flag), is natural; all else inline.

Verification
REQ-040 DELAY_SLOTS=1: beq taken at pc 0x3000, then slot at 0x3004 -> slot in_slot=1, epc_base=0x3000, redirect=1 on slot advance.
REQ-041 DELAY_SLOTS=1, LIKELY_EN=1: beql not taken at 0x3000 -> slot annul=1, redirect=0, IDLE after.
REQ-042 DELAY_SLOTS=2: jal at 0x3000, stall held 3 cycles during first slot -> slots_left stays 1, redirect only on second slot advance.
REQ-043 ERET_SLOT=0: eret at 0x4180 -> redirect=1 same cycle, in_slot=0 next instruction.
REQ-044 flush asserted in SLOT with count=1 -> IDLE next edge, in_slot=0, no redirect.
REQ-045 Branch inside delay slot -> slot_err one-cycle pulse; reset_n pulsed low mid-SLOT -> all outputs 0 immediately.
